// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory master.
// Size encodings, FSM states and byte-enable construction.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACCESS2,
        RESP
    } state_t;

    function automatic logic [3:0] be_of(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] be;
        be = BE_NONE;
        unique case (1'b1)
            (size == SZ_BYTE): be = 4'b0001 << off;
            (size == SZ_HALF): be = off[1] ? BE_HI : BE_LO;
            (size == SZ_WORD): be = BE_WORD;
            default:           be = BE_NONE;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        return ((size == SZ_HALF) && off[0]) ||
               ((size == SZ_WORD) && (off != 2'd0));
    endfunction

    function automatic logic [1:0] last_beat(input logic [1:0] size);
        logic [1:0] lb;
        lb = 2'd0;
        unique case (1'b1)
            (size == SZ_HALF): lb = 2'd1;
            (size == SZ_WORD): lb = 2'd3;
            default:           lb = 2'd0;
        endcase
        return lb;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: picks bytes at the offset out of a word pair
// and sign/zero-extends them to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] pair,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [31:0] sh;

    assign sh = 32'(pair >> {off, 3'b000});

    always_comb begin
        data = sh;
        unique case (1'b1)
            (size == SZ_BYTE): data = {{24{~uns & sh[7]}}, sh[7:0]};
            (size == SZ_HALF): data = {{16{~uns & sh[15]}}, sh[15:0]};
            default:           data = sh;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the MEM stage and a byte-enabled memory.
// MISALIGN_SPLIT_EN: split misaligned accesses instead of rejecting them.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W               = 32,
    parameter bit WORD_ALIGN_ONLY_ADDR = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t            state;
    logic              r_store;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [ADDR_W-1:0] r_addr;
    logic              reject;
    logic [63:0]       pair;
    logic [31:0]       ld_data;

    function automatic logic [ADDR_W-1:0] out_addr(
        input logic [ADDR_W-1:0] a
    );
        if (WORD_ALIGN_ONLY_ADDR)
            return {a[ADDR_W-1:2], 2'b00};
        return a;
    endfunction

`ifdef MISALIGN_SPLIT_EN
    logic [31:0]       r_wdata;
    logic [31:0]       word_a;
    logic [1:0]        beat;
    logic [1:0]        nbeat;
    logic              split;
    logic [ADDR_W-1:0] nb_addr;
    logic [ADDR_W-1:0] next_word;

    assign split     = misaligned(r_size, r_addr[1:0]);
    assign nbeat     = beat + 2'd1;
    assign nb_addr   = r_addr + ADDR_W'(nbeat);
    assign next_word = {r_addr[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
    assign reject    = (req_size == SZ_ILL);
    assign pair      = (state == ACCESS2) ? {mem_rdata, word_a}
                                          : {32'h0, mem_rdata};
`else
    assign reject = (req_size == SZ_ILL) ||
                    misaligned(req_size, req_addr[1:0]);
    assign pair   = {32'h0, mem_rdata};
`endif

    assign req_ready = (state == IDLE) & ~reset;
    assign mem_we    = r_store & ~reset &
                       ((state == ACCESS) | (state == ACCESS2));

    lsu_load_align u_align (
        .pair (pair),
        .off  (r_addr[1:0]),
        .size (r_size),
        .uns  (r_uns),
        .data (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            r_store   <= 1'b0;
            r_size    <= SZ_BYTE;
            r_uns     <= 1'b0;
            r_addr    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= BE_NONE;
            mem_wdata <= '0;
`ifdef MISALIGN_SPLIT_EN
            r_wdata   <= '0;
            word_a    <= '0;
            beat      <= 2'd0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: if (req_valid) begin
                    r_store <= req_store;
                    r_size  <= req_size;
                    r_uns   <= req_unsigned;
                    r_addr  <= req_addr;
`ifdef MISALIGN_SPLIT_EN
                    r_wdata <= req_wdata;
                    beat    <= 2'd0;
`endif
                    if (reject) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        state     <= ACCESS;
                        mem_addr  <= out_addr(req_addr);
                        mem_be    <= be_of(req_size, req_addr[1:0]);
                        mem_wdata <= req_wdata;
`ifdef MISALIGN_SPLIT_EN
                        // first beat: lowest byte of a store, word A of a load
                        if (misaligned(req_size, req_addr[1:0])) begin
                            mem_be    <= req_store ?
                                         4'b0001 << req_addr[1:0] : BE_WORD;
                            mem_wdata <= {24'h0, req_wdata[7:0]};
                        end
`endif
                    end
                end
                ACCESS: begin
`ifdef MISALIGN_SPLIT_EN
                    if (split) begin
                        state <= ACCESS2;
                        if (r_store) begin
                            beat      <= nbeat;
                            mem_addr  <= out_addr(nb_addr);
                            mem_be    <= 4'b0001 << nb_addr[1:0];
                            mem_wdata <= {24'h0,
                                          r_wdata[{nbeat, 3'b000} +: 8]};
                        end else begin
                            word_a   <= mem_rdata;
                            mem_addr <= next_word;
                            mem_be   <= BE_WORD;
                        end
                    end else
`endif
                    begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= r_store ? 32'h0 : ld_data;
                        mem_be    <= BE_NONE;
                    end
                end
                ACCESS2: begin
`ifdef MISALIGN_SPLIT_EN
                    if (r_store && (beat != last_beat(r_size))) begin
                        beat      <= nbeat;
                        mem_addr  <= out_addr(nb_addr);
                        mem_be    <= 4'b0001 << nb_addr[1:0];
                        mem_wdata <= {24'h0,
                                      r_wdata[{nbeat, 3'b000} +: 8]};
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= r_store ? 32'h0 : ld_data;
                        mem_be    <= BE_NONE;
                    end
`else
                    state  <= IDLE;
                    mem_be <= BE_NONE;
`endif
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator sitting between the CPU MEM stage and the byte-enabled data memory port.
- Accepts one load or store request at a time and generates word address, byte enables and right-aligned store data for the memory.
- Extracts, aligns and sign/zero-extends load data from the full memory word.
- Owns the data-memory write strobe; the data memory is a pure responder to this block.

Parameters:
- ADDR_W, 32, request/memory address width; address arithmetic is modulo 2^ADDR_W.
- WORD_ALIGN_ONLY_ADDR, 1, when 1 mem_addr[1:0] is driven 2'b00; when 0 it carries the request byte offset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept; equals (state==IDLE) & ~reset
- req_store  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_unsigned  in  1  loads only: zero-extend when 1
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request rejected, no memory write done
- mem_addr  out  ADDR_W  memory address
- mem_be  out  4  byte enables, bit k = byte lane k (little-endian)
- mem_we  out  1  write strobe; memory writes at the clk edge where it is high
- mem_wdata  out  32  store data, right-aligned (byte in [7:0], half in [15:0]); responder steers it to the lane selected by mem_be
- mem_rdata  in  32  combinational read word for mem_addr

Behaviour:
- Reset values: state IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0; all request registers cleared.
- Handshake: a request is accepted on the edge where req_valid & req_ready. Fields are captured into registers, so req_* may change afterwards.

States:
- IDLE: accept request → ACCESS.
  - If size==3, or the access is misaligned and MISALIGN_SPLIT_EN is undefined → RESP with err=1.
- ACCESS: drive mem_addr, mem_be and mem_wdata from registers; mem_we = req_store & ~reset. Sample mem_rdata at the end of the cycle. → ACCESS2 if a split beat remains, else RESP.
- ACCESS2: split beats only (see Optional Feature).
- RESP: rsp_valid=1 for exactly one cycle → IDLE. The next request may be accepted in the cycle after RESP.

Latency and encoding:
- Aligned request: acceptance edge E, ACCESS during cycle E+1, rsp_valid during cycle E+2. Throughput is one request per 3 cycles.
- Error request: rsp_valid during cycle E+1. mem_we and mem_be stay 0 throughout.
- Aligned byte enables: byte → 4'b0001<<addr[1:0]; half offset 0 → 0011, offset 2 → 1100; word → 1111.
- Misaligned means: half with addr[0]=1, or word with addr[1:0]≠0.
- Outside ACCESS/ACCESS2, mem_we=0 and mem_be=0.
- Load extraction: select lane(s) by offset. Sign-extend from bit 7 or 15 unless req_unsigned. Word passes through unchanged.
- Reset mid-operation: returns to IDLE on that edge; mem_we is gated low in the reset cycle; no rsp_valid is issued for the aborted request.

Optional Feature:
- Macro: MISALIGN_SPLIT_EN.
- Defined, misaligned load: read word A=addr&~3, then A+4 (wraps modulo 2^ADDR_W). Concatenate {wordB,wordA}, extract bytes at offset..offset+size-1, then extend.
- Defined, misaligned store: one beat per byte, mem_be one-hot, mem_wdata[7:0]=the corresponding byte. Half = 2 beats, word = 4 beats, ascending address order. Latency = beats+1 cycles after acceptance.
- Undefined: misaligned requests complete with rsp_err=1, no memory access.

Decomposition:
- lsu_pkg holds:
  - size encodings (SZ_BYTE/SZ_HALF/SZ_WORD);
  - state enum (IDLE/ACCESS/ACCESS2/RESP);
  - BE constants (BE_WORD=4'b1111, BE_LO=4'b0011, BE_HI=4'b1100);
  - function be_of(size, offset).
- One sub-module, lsu_load_align: combinational; inputs are the 64-bit word pair, offset, size and unsigned flag; output is the 32-bit extended result.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF → mem_be=1111, mem_we high one cycle at addr 0x10; rsp_valid 2 cycles after accept, rsp_err=0.
- SB addr 0x13, wdata 0x000000A5 → mem_be=1000, mem_wdata[7:0]=0xA5; a following LW 0x10 with memory 0xA5ADBEEF returns 0xA5ADBEEF.
- LH addr 0x12 on word 0x8001_1234 → 0xFFFF8001; LHU → 0x00008001; LB addr 0x11 → 0x00000012.
- Without MISALIGN_SPLIT_EN: LW addr 0x21 → rsp_err=1, rsp_rdata=0, mem_we never high. size=3 → rsp_err=1 in either build.
- With MISALIGN_SPLIT_EN: LW addr 0x0E on words [0x0C]=0x44332211 and [0x10]=0x88776655 → 0x66554433. SH addr 0xFFFFFFFF → byte beats at 0xFFFFFFFF then 0x00000000.
- Reset asserted during ACCESS of an SW → mem_we=0 that cycle, no rsp_valid, req_ready=1 the cycle after reset deasserts.
